t_row_store: RTL
================

# t_row_store

Responder end of the DataProcessor SRAM interface. The block holds the T row (char, V, F per group) in two ping-pong banks. It serves word read requests from the PE-side data processor and absorbs word writes of the newly computed row. It also packs the initial T sequence from the top level into the first bank before calculation starts.

## Interface
Parameters:
- `V_E_F_Bit`, 10: score width; groups store `V_E_F_Bit-1` bits each of V and F.
- `BIT_P_GROUP`, 20: `2 + 2*(V_E_F_Bit-1)`; one group is {t[1:0], v, f}.
- `T_per_word`, 4: groups per memory word.
- `HEADER_BIT`, 4: {valid, count[2:0]}.
- `Sram_Word`, 84: `HEADER_BIT + BIT_P_GROUP*T_per_word`.
- `Max_T_size_log`, 12: T length width; word address is `Max_T_size_log-2` (10) bits, giving 1024 words per bank.

Ports:
- `clk`: in, 1. Single clock.
- `rst_n`: in, 1. Reset is synchronous and active-low.
- `i_T_size`: in, 12. T length, 1..4095. Stable from LOAD until reset-address.
- `i_load_valid`: in, 1. Host T character valid.
- `i_load_t`: in, 2. Host T character.
- `o_load_done`: out, 1. Set when `i_T_size` characters have been stored.
- `i_start_calc`: in, 1. Moves the block LOAD→RUN.
- `i_sram_request`: in, 1. Read request (level, may stay high).
- `o_request_data`: out, 84. Response word; MSB = valid.
- `i_sram_send`: in, 1. Write strobe, one cycle per word.
- `i_send_data`: in, 80. Packed groups, first group at MSB.
- `i_sram_init`: in, 1. Swap banks.
- `i_sram_rst_addr`: in, 1. End of job; return to LOAD.

## Operation
- Word layout:
  - `[83]` valid.
  - `[82:80]` group count; 0 means full (4).
  - `[79:0]` groups, first group at `[79:60]`.
- Last word index is `L = (i_T_size-1)>>2`.
  - Word L carries count `i_T_size[1:0]`.
  - All other words carry count 0.
- Top FSM:
  - LOAD: packs chars MSB-first into a word with v=f=0. The word is written to bank `rd_bank` when 4 chars are collected or the char count reaches `i_T_size`.
  - `o_load_done` is set when the char count reaches `i_T_size`.
  - `i_start_calc` while `o_load_done`=1 → RUN, with `rd_addr`=`wr_addr`=0. `i_start_calc` while `o_load_done`=0 is ignored.
  - `i_load_valid` is ignored in RUN.
  - RUN → LOAD on `i_sram_rst_addr`.
- Read FSM (RUN only): RD_IDLE → RD_MEM → RD_OUT → RD_IDLE.
  - `i_sram_request` is sampled only in RD_IDLE.
  - Requests seen in RD_MEM and RD_OUT are ignored; they are stale.
  - At RD_MEM, `rd_addr` advances and wraps from L to 0, so the row is re-read on every S pass.
- Write (RUN only): `i_sram_send` writes `i_send_data` to `wr_bank[wr_addr]`; `wr_addr` advances and wraps from L to 0. The count field is not stored; it is regenerated on read from the address.
- `i_sram_init`: swaps `rd_bank`/`wr_bank` and zeroes `rd_addr` and `wr_addr`.
- `i_sram_rst_addr`:
  - Sets `rd_bank`=0, `wr_bank`=1.
  - Zeroes both addresses, the load counter and `o_load_done`.
  - Aborts any in-flight read.
  - The FSM goes to LOAD.

## Timing
- Read latency: a request high in cycle c (RD_IDLE) produces `o_request_data` valid for exactly cycle c+2. The next request is accepted from cycle c+3 at the earliest.
- `o_request_data` is registered. Its MSB is 0 in every cycle other than a response cycle; the data bits hold their last value.
- Send and init in the same cycle: the write lands in the old `wr_bank` at the old `wr_addr`, then the swap occurs. That word is readable after the swap.
- Init with a read in flight: the response still completes from the pre-swap bank and address. The read address is then 0 of the new bank.
- Reset-address with a read in flight: no valid response is produced.
- Load write and `i_start_calc` in the same cycle: the write completes, then the FSM enters RUN.
- Reset values: all outputs 0, FSM in LOAD, RD_IDLE, `rd_bank`=0, `wr_bank`=1, all counters 0. Memory contents are don't-care.
- Reset applied mid-operation overrides everything on the next edge.

## Structure
- Shared package `sw_pkg`: `V_E_F_Bit`, `BIT_P_GROUP`, `T_per_word`, `HEADER_BIT`, `Sram_Word`, `Max_T_size_log`. Group and header field offsets are defined there.
- Sub-module `t_bank_ram`: 1024×80 single-port, synchronous-read RAM, instantiated twice.
  - The write bank and the read bank always differ.
  - In LOAD only `rd_bank` is written.

## Test plan
- Load `i_T_size`=6 with chars 0,1,2,3,0,1, start, then issue three requests:
  - header `4'b1000`, data groups t=0,1,2,3;
  - header `4'b1010`, groups t=0,1;
  - header `4'b1000` again (wrap).
- Hold `i_sram_request` high 4 cycles from c → exactly one valid at c+2, a second valid at c+5.
- Send words 0xA…, 0xB… with `i_T_size`=8, then init, then request ×2 → responses carry 0xA… then 0xB…, both with count 0.
- Send (data X) and init in the same cycle at `wr_addr`=0 → the first post-init request returns X.
- Request at c, `i_sram_rst_addr` at c+1 → no valid at c+2, `o_load_done`=0, FSM in LOAD.
- Drive `rst_n`=0 for one cycle mid-RUN → next cycle `o_request_data`=0 and `o_load_done`=0; requests ignored until reload and start.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared widths, word layout offsets and FSM encodings for the T row store.
package sw_pkg;

  localparam int V_E_F_Bit      = 10;
  localparam int BIT_P_GROUP    = 2 + 2 * (V_E_F_Bit - 1);
  localparam int T_per_word     = 4;
  localparam int HEADER_BIT     = 4;
  localparam int Sram_Word      = HEADER_BIT + BIT_P_GROUP * T_per_word;
  localparam int Max_T_size_log = 12;

  localparam int DATA_W    = BIT_P_GROUP * T_per_word;
  localparam int ADDR_W    = Max_T_size_log - 2;
  localparam int BANK_DEPTH = 1 << ADDR_W;

  // Group layout {t[1:0], v, f}, offsets relative to the group LSB
  localparam int GRP_T_W   = 2;
  localparam int GRP_VF_W  = V_E_F_Bit - 1;
  localparam int GRP_T_LSB = BIT_P_GROUP - GRP_T_W;
  localparam int GRP_V_LSB = GRP_VF_W;
  localparam int GRP_F_LSB = 0;

  // Header layout {valid, count[2:0]} above the group data
  localparam int HDR_VALID   = Sram_Word - 1;
  localparam int HDR_CNT_LSB = DATA_W;
  localparam int HDR_CNT_W   = HEADER_BIT - 1;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } top_state_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_MEM  = 2'd1,
    RD_OUT  = 2'd2
  } rd_state_t;

  // Only the last word of the row can be partial; count 0 encodes a full word
  function automatic logic [HDR_CNT_W-1:0] word_count(
    input logic [ADDR_W-1:0]         addr,
    input logic [ADDR_W-1:0]         last,
    input logic [Max_T_size_log-1:0] t_size
  );
    logic [HDR_CNT_W-1:0] cnt;
    cnt = '0;
    if (addr == last) cnt = {1'b0, t_size[1:0]};
    return cnt;
  endfunction

endpackage

// File: rtl/t_row_store_if.sv
// DataProcessor-side SRAM bus: read request/response, row write strobe, bank control.
interface t_row_store_if;
  import sw_pkg::*;

  logic                 i_sram_request;
  logic [Sram_Word-1:0] o_request_data;
  logic                 i_sram_send;
  logic [DATA_W-1:0]    i_send_data;
  logic                 i_sram_init;
  logic                 i_sram_rst_addr;

  modport master (
    output i_sram_request, i_sram_send, i_send_data, i_sram_init, i_sram_rst_addr,
    input  o_request_data
  );

  modport slave (
    input  i_sram_request, i_sram_send, i_send_data, i_sram_init, i_sram_rst_addr,
    output o_request_data
  );

endinterface

// File: rtl/t_bank_ram.sv
// One T row bank: single-port RAM with synchronous read.
module t_bank_ram
  import sw_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [BANK_DEPTH];

  // rdata is only refreshed on read cycles so an in-flight response survives a write
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    else    rdata     <= mem[addr];
  end

endmodule

// File: rtl/t_row_store.sv
// T row store: host load packing into the read bank, then ping-pong read/write service.
//   state   | meaning
//   ST_LOAD | packing host T chars into rd_bank, requests ignored
//   ST_RUN  | serving reads from rd_bank, absorbing writes into wr_bank
//   RD_IDLE | waiting for a read request (RUN only)
//   RD_MEM  | RAM data available, response register loaded
//   RD_OUT  | response valid on o_request_data
module t_row_store
  import sw_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [Max_T_size_log-1:0] i_T_size,
  input  logic                      i_load_valid,
  input  logic [1:0]                i_load_t,
  output logic                      o_load_done,
  input  logic                      i_start_calc,
  t_row_store_if.slave              sram
);

  top_state_t st_q, st_d;
  rd_state_t  rd_q, rd_d;

  logic                      rd_bank, rd_bank_q;
  logic [ADDR_W-1:0]         rd_addr, rd_addr_q, wr_addr, last_idx;
  logic [Max_T_size_log-1:0] load_cnt, t_minus1;
  logic [DATA_W-1:0]         load_word, pack_word;
  logic                      load_fire, load_last, load_wr;
  logic                      run_send, run_init, rd_issue, start_ok;
  logic                      ram_we, ram_wbank;
  logic [ADDR_W-1:0]         ram_waddr;
  logic [DATA_W-1:0]         ram_wdata;
  logic [1:0]                bank_we;
  logic [ADDR_W-1:0]         bank_addr  [2];
  logic [DATA_W-1:0]         bank_rdata [2];

  assign t_minus1  = i_T_size - Max_T_size_log'(1);
  assign last_idx  = t_minus1[Max_T_size_log-1:2];

  assign load_fire = (st_q == ST_LOAD) && i_load_valid && !o_load_done;
  assign load_last = (load_cnt + Max_T_size_log'(1)) == i_T_size;
  assign load_wr   = load_fire && ((load_cnt[1:0] == 2'd3) || load_last);
  assign start_ok  = (st_q == ST_LOAD) && i_start_calc && o_load_done && !sram.i_sram_rst_addr;
  assign run_send  = (st_q == ST_RUN) && sram.i_sram_send;
  assign run_init  = (st_q == ST_RUN) && sram.i_sram_init;
  assign rd_issue  = (st_q == ST_RUN) && (rd_q == RD_IDLE) && sram.i_sram_request
                     && !sram.i_sram_rst_addr;

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] last);
    return (a == last) ? '0 : a + ADDR_W'(1);
  endfunction

  // First char of a word starts from a clean slate so v and f load as zero
  always_comb begin
    pack_word = (load_cnt[1:0] == 2'd0) ? '0 : load_word;
    for (int g = 0; g < T_per_word; g++) begin
      if (int'(load_cnt[1:0]) == g)
        pack_word[DATA_W-1-g*BIT_P_GROUP -: GRP_T_W] = i_load_t;
    end
  end

  assign ram_we    = load_wr || run_send;
  assign ram_wbank = (st_q == ST_LOAD) ? rd_bank : ~rd_bank;
  assign ram_waddr = (st_q == ST_LOAD) ? load_cnt[Max_T_size_log-1:2] : wr_addr;
  assign ram_wdata = (st_q == ST_LOAD) ? pack_word : sram.i_send_data;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_we[b]   = ram_we && (ram_wbank == b[0]);
      bank_addr[b] = bank_we[b] ? ram_waddr : rd_addr;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    t_bank_ram u_ram (
      .clk   (clk),
      .we    (bank_we[b]),
      .addr  (bank_addr[b]),
      .wdata (ram_wdata),
      .rdata (bank_rdata[b])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= ST_LOAD;
      rd_q <= RD_IDLE;
    end else begin
      st_q <= st_d;
      rd_q <= rd_d;
    end
  end

  always_comb begin
    st_d = st_q;
    rd_d = rd_q;
    case (st_q)
      ST_LOAD: if (start_ok) st_d = ST_RUN;
      ST_RUN:  if (sram.i_sram_rst_addr) st_d = ST_LOAD;
      default: st_d = ST_LOAD;
    endcase
    case (rd_q)
      RD_IDLE: if (rd_issue) rd_d = RD_MEM;
      RD_MEM:  rd_d = RD_OUT;
      RD_OUT:  rd_d = RD_IDLE;
      default: rd_d = RD_IDLE;
    endcase
    if (sram.i_sram_rst_addr) rd_d = RD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sram.o_request_data <= '0;
      o_load_done         <= 1'b0;
      rd_bank             <= 1'b0;
      rd_bank_q           <= 1'b0;
      rd_addr             <= '0;
      rd_addr_q           <= '0;
      wr_addr             <= '0;
      load_cnt            <= '0;
      load_word           <= '0;
    end else begin
      sram.o_request_data[HDR_VALID] <= 1'b0;
      if ((rd_q == RD_MEM) && !sram.i_sram_rst_addr)
        sram.o_request_data <= {1'b1, word_count(rd_addr_q, last_idx, i_T_size),
                                bank_rdata[rd_bank_q]};

      if (sram.i_sram_rst_addr) begin
        rd_bank     <= 1'b0;
        rd_addr     <= '0;
        wr_addr     <= '0;
        load_cnt    <= '0;
        o_load_done <= 1'b0;
      end else begin
        if (load_fire) begin
          load_word <= pack_word;
          load_cnt  <= load_cnt + Max_T_size_log'(1);
          if (load_last) o_load_done <= 1'b1;
        end
        if (start_ok) begin
          rd_addr <= '0;
          wr_addr <= '0;
        end
        // Address and bank are captured at issue so a swap mid-read cannot redirect it
        if (rd_issue) begin
          rd_addr_q <= rd_addr;
          rd_bank_q <= rd_bank;
          rd_addr   <= wrap_inc(rd_addr, last_idx);
        end
        if (run_send) wr_addr <= wrap_inc(wr_addr, last_idx);
        if (run_init) begin
          rd_bank <= ~rd_bank;
          rd_addr <= '0;
          wr_addr <= '0;
        end
      end
    end
  end

endmodule
